// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C register-window target.
package i2c_pkg;

   localparam int I2C_ADDR_W = 7;
   localparam int I2C_BYTE_W = 8;

   // Level placed on SDA by the receiver of a byte during the ninth clock
   localparam logic ACK  = 1'b0;
   localparam logic NACK = 1'b1;

   typedef enum logic [3:0] {
      IDLE,
      ADDR,
      ADDR_ACK,
      PTR,
      PTR_ACK,
      WDATA,
      WDATA_ACK,
      RDATA,
      RD_MACK,
      IGNORE
   } i2c_tgt_state_t;

endpackage

// File: rtl/i2c_line_cond.sv
// Synchroniser plus glitch filter for one I2C line; emits one-cycle
// rise/fall pulses of the filtered level. Lines idle high, so reset is 1.
module i2c_line_cond #(
   parameter int SYNC_STAGES = 2,
   parameter int FILTER_LEN  = 3
)(
   input  logic clock,
   input  logic reset,
   input  logic pin,
   output logic level,
   output logic rise,
   output logic fall
);

   localparam int CW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;

   logic [SYNC_STAGES-1:0] sync;
   logic [CW-1:0]          cnt;
   logic                   level_d;
   logic                   sampled;

   assign sampled = sync[SYNC_STAGES-1];

   // Bring the asynchronous pin into the clock domain
   always_ff @(posedge clock or posedge reset) begin
      if (reset) sync <= '1;
      else       sync <= {sync[SYNC_STAGES-2:0], pin};
   end

   // Accept a new level only after FILTER_LEN consecutive differing samples
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         level   <= 1'b1;
         level_d <= 1'b1;
         cnt     <= '0;
      end else begin
         level_d <= level;
         if (sampled != level) begin
            if (cnt == CW'(FILTER_LEN - 1)) begin
               level <= sampled;
               cnt   <= '0;
            end else begin
               cnt <= cnt + 1'b1;
            end
         end else begin
            cnt <= '0;
         end
      end
   end

   assign rise = level & ~level_d;
   assign fall = ~level & level_d;

endmodule

// File: rtl/i2c_reg_target.sv
// I2C target exposing a register window: pointer byte, auto-incrementing
// write/read bursts, repeated START, NACK of out-of-range pointers.
module i2c_reg_target
   import i2c_pkg::*;
#(
   parameter logic [I2C_ADDR_W-1:0] I2C_ADDRESS = 7'h49,
   parameter int NUM_REGS    = 16,
   parameter int SYNC_STAGES = 2,
   parameter int FILTER_LEN  = 3,
   localparam int PTR_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
)(
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  scl_in,
   input  logic                  sda_in,
   output logic                  sda_oe,
   output logic                  wr_valid,
   output logic [PTR_W-1:0]      wr_addr,
   output logic [I2C_BYTE_W-1:0] wr_data,
   output logic                  rd_req,
   output logic [PTR_W-1:0]      rd_addr,
   input  logic [I2C_BYTE_W-1:0] rd_data,
   output logic                  busy
);

   logic scl_lvl, scl_rise, scl_fall;
   logic sda_lvl, sda_rise, sda_fall;
   logic start, stop;

   i2c_tgt_state_t state, state_next;
   logic [3:0]            bit_cnt;
   logic [I2C_BYTE_W-1:0] shift;
   logic [I2C_BYTE_W-1:0] tx;
   logic [PTR_W-1:0]      ptr;
   logic                  ld_pend, wr_pend;

   logic shift_en, cnt_clr, oe_set, oe_clr, oe_tx, ptr_load;
   logic rd_first, rd_next, wr_arm, busy_set, busy_clr;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      if (p == PTR_W'(NUM_REGS - 1)) return '0;
      else                           return p + 1'b1;
   endfunction

   i2c_line_cond #(.SYNC_STAGES(SYNC_STAGES), .FILTER_LEN(FILTER_LEN)) u_scl (
      .clock(clock), .reset(reset), .pin(scl_in),
      .level(scl_lvl), .rise(scl_rise), .fall(scl_fall)
   );

   i2c_line_cond #(.SYNC_STAGES(SYNC_STAGES), .FILTER_LEN(FILTER_LEN)) u_sda (
      .clock(clock), .reset(reset), .pin(sda_in),
      .level(sda_lvl), .rise(sda_rise), .fall(sda_fall)
   );

   assign start = sda_fall & scl_lvl;
   assign stop  = sda_rise & scl_lvl;

   // State register
   always_ff @(posedge clock or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_next;
   end

   // Next state and datapath strobes; START/STOP override bit handling
   always_comb begin
      state_next = state;
      shift_en = 1'b0;  cnt_clr  = 1'b0;  oe_set   = 1'b0;  oe_clr = 1'b0;
      oe_tx    = 1'b0;  ptr_load = 1'b0;  rd_first = 1'b0;  rd_next = 1'b0;
      wr_arm   = 1'b0;  busy_set = 1'b0;  busy_clr = 1'b0;
      if (start) begin
         state_next = ADDR;  cnt_clr = 1'b1;  oe_clr = 1'b1;  busy_clr = 1'b1;
      end else if (stop) begin
         state_next = IDLE;  cnt_clr = 1'b1;  oe_clr = 1'b1;  busy_clr = 1'b1;
      end else begin
         case (state)
            ADDR: begin
               if (scl_rise) shift_en = 1'b1;
               else if (scl_fall && bit_cnt == 4'd8) begin
                  cnt_clr = 1'b1;
                  if (shift[7:1] == I2C_ADDRESS) begin
                     state_next = ADDR_ACK;  oe_set = 1'b1;  busy_set = 1'b1;
                  end else begin
                     state_next = IGNORE;
                  end
               end
            end
            ADDR_ACK: begin
               // A read fetches its first byte while the master clocks the ACK
               if (scl_rise && shift[0]) begin
                  state_next = RDATA;  rd_first = 1'b1;
               end else if (scl_fall && !shift[0]) begin
                  state_next = PTR;  oe_clr = 1'b1;
               end
            end
            PTR: begin
               if (scl_rise) shift_en = 1'b1;
               else if (scl_fall && bit_cnt == 4'd8) begin
                  cnt_clr = 1'b1;
                  if ({24'd0, shift} < 32'(NUM_REGS)) begin
                     state_next = PTR_ACK;  ptr_load = 1'b1;  oe_set = 1'b1;
                  end else begin
                     state_next = IGNORE;  busy_clr = 1'b1;
                  end
               end
            end
            WDATA: begin
               if (scl_rise) begin
                  shift_en = 1'b1;
                  if (bit_cnt == 4'd7) wr_arm = 1'b1;
               end else if (scl_fall && bit_cnt == 4'd8) begin
                  state_next = WDATA_ACK;  cnt_clr = 1'b1;  oe_set = 1'b1;
               end
            end
            PTR_ACK, WDATA_ACK: begin
               if (scl_fall) begin
                  state_next = WDATA;  oe_clr = 1'b1;
               end
            end
            RDATA: begin
               if (scl_fall) begin
                  if (bit_cnt == 4'd8) begin
                     state_next = RD_MACK;  cnt_clr = 1'b1;  oe_clr = 1'b1;
                  end else begin
                     oe_tx = 1'b1;
                  end
               end
            end
            RD_MACK: begin
               if (scl_rise) begin
                  if (sda_lvl == ACK) begin
                     state_next = RDATA;  rd_next = 1'b1;
                  end else begin
                     state_next = IGNORE;  busy_clr = 1'b1;
                  end
               end
            end
            default: ;
         endcase
      end
   end

   // Bit counter, shifters, pointer and registered outputs
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         bit_cnt  <= '0;
         shift    <= '0;
         tx       <= '0;
         ptr      <= '0;
         ld_pend  <= 1'b0;
         wr_pend  <= 1'b0;
         sda_oe   <= 1'b0;
         wr_valid <= 1'b0;
         wr_addr  <= '0;
         wr_data  <= '0;
         rd_req   <= 1'b0;
         rd_addr  <= '0;
         busy     <= 1'b0;
      end else begin
         wr_valid <= 1'b0;
         rd_req   <= 1'b0;
         ld_pend  <= rd_first | rd_next;
         wr_pend  <= wr_arm;

         if (cnt_clr)                bit_cnt <= '0;
         else if (shift_en || oe_tx) bit_cnt <= bit_cnt + 4'd1;

         if (shift_en) shift <= {shift[6:0], sda_lvl};

         if (oe_set)      sda_oe <= 1'b1;
         else if (oe_clr) sda_oe <= 1'b0;
         else if (oe_tx)  sda_oe <= ~tx[7];

         if (oe_tx)        tx <= {tx[6:0], 1'b0};
         else if (ld_pend) tx <= rd_data;

         if (busy_clr)      busy <= 1'b0;
         else if (busy_set) busy <= 1'b1;

         if (rd_first) begin
            rd_req  <= 1'b1;
            rd_addr <= ptr;
         end else if (rd_next) begin
            rd_req  <= 1'b1;
            rd_addr <= ptr_inc(ptr);
            ptr     <= ptr_inc(ptr);
         end else if (ptr_load) begin
            ptr <= shift[PTR_W-1:0];
         end else if (wr_pend) begin
            wr_valid <= 1'b1;
            wr_addr  <= ptr;
            wr_data  <= shift;
            ptr      <= ptr_inc(ptr);
         end
      end
   end

endmodule

// File: tb/tb_i2c_reg_target.sv
// Directed bench for i2c_reg_target: a bit-banged I2C master, a register
// bank model on the read port, and a monitor logging write/read strobes.
module tb_i2c_reg_target;

   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic       scl_m = 1'b1;
   logic       sda_m = 1'b1;
   logic       glitch = 1'b0;
   logic       scl_in, sda_in, sda_oe, wr_valid, rd_req, busy;
   logic [3:0] wr_addr, rd_addr;
   logic [7:0] wr_data, rd_data;
   logic [7:0] regs [16];

   int errors = 0;
   int checks = 0;
   int wr_cnt = 0, rd_cnt = 0, oe_cycles = 0, overlap = 0, long_pulse = 0;
   logic [3:0] wr_a_log [64];
   logic [7:0] wr_d_log [64];
   logic [3:0] rd_a_log [64];
   logic       wr_prev = 1'b0, rd_prev = 1'b0;

   always #5 clock = ~clock;

   assign scl_in  = scl_m;
   assign sda_in  = (sda_m & ~sda_oe) ^ glitch;
   assign rd_data = regs[rd_addr];

   i2c_reg_target #(.I2C_ADDRESS(7'h49), .NUM_REGS(16), .SYNC_STAGES(2), .FILTER_LEN(3)) dut (
      .clock(clock), .reset(reset), .scl_in(scl_in), .sda_in(sda_in), .sda_oe(sda_oe),
      .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data),
      .rd_req(rd_req), .rd_addr(rd_addr), .rd_data(rd_data), .busy(busy)
   );

   always @(negedge clock) begin
      if (wr_valid && wr_cnt < 64) begin
         wr_a_log[wr_cnt] = wr_addr;
         wr_d_log[wr_cnt] = wr_data;
      end
      if (wr_valid) wr_cnt++;
      if (rd_req && rd_cnt < 64) rd_a_log[rd_cnt] = rd_addr;
      if (rd_req) rd_cnt++;
      if (sda_oe) oe_cycles++;
      if (wr_valid && rd_req) overlap++;
      if ((wr_valid && wr_prev) || (rd_req && rd_prev)) long_pulse++;
      wr_prev = wr_valid;
      rd_prev = rd_req;
   end

   task automatic wait_clk(input int n);
      repeat (n) @(negedge clock);
   endtask

   task automatic send_bit(input logic b, input logic g);
      sda_m = b;  wait_clk(10);
      scl_m = 1'b1;  wait_clk(10);
      glitch = g;  wait_clk(1);
      glitch = 1'b0;  wait_clk(9);
      scl_m = 1'b0;  wait_clk(10);
   endtask

   task automatic write_byte(input logic [7:0] d, input int gbit, output logic ack);
      for (int i = 0; i < 8; i++) send_bit(d[7-i], i == gbit);
      sda_m = 1'b1;  wait_clk(10);
      scl_m = 1'b1;  wait_clk(10);
      ack = sda_in;  wait_clk(10);
      scl_m = 1'b0;  wait_clk(10);
   endtask

   task automatic read_bits(input int n, output logic [7:0] d);
      logic [7:0] t;
      t = '0;
      for (int i = 0; i < n; i++) begin
         sda_m = 1'b1;  wait_clk(10);
         scl_m = 1'b1;  wait_clk(10);
         t = {t[6:0], sda_in};  wait_clk(10);
         scl_m = 1'b0;  wait_clk(10);
      end
      d = t;
   endtask

   task automatic read_byte(input logic mack, output logic [7:0] d);
      read_bits(8, d);
      send_bit(mack, 1'b0);
   endtask

   task automatic i2c_start();
      sda_m = 1'b1;  wait_clk(10);
      scl_m = 1'b1;  wait_clk(20);
      sda_m = 1'b0;  wait_clk(20);
      scl_m = 1'b0;  wait_clk(10);
   endtask

   task automatic i2c_stop();
      sda_m = 1'b0;  wait_clk(10);
      scl_m = 1'b1;  wait_clk(20);
      sda_m = 1'b1;  wait_clk(20);
   endtask

   task automatic test_reset();
      wait_clk(4);
      reset = 1'b0;
      wait_clk(3);
      checks++; if (sda_oe !== 1'b0)   begin errors++; $display("FAIL reset_sda_oe got %b want 0", sda_oe); end
      checks++; if (wr_valid !== 1'b0) begin errors++; $display("FAIL reset_wr_valid got %b want 0", wr_valid); end
      checks++; if (rd_req !== 1'b0)   begin errors++; $display("FAIL reset_rd_req got %b want 0", rd_req); end
      checks++; if (wr_addr !== 4'd0)  begin errors++; $display("FAIL reset_wr_addr got %0d want 0", wr_addr); end
      checks++; if (wr_data !== 8'd0)  begin errors++; $display("FAIL reset_wr_data got %0h want 0", wr_data); end
      checks++; if (rd_addr !== 4'd0)  begin errors++; $display("FAIL reset_rd_addr got %0d want 0", rd_addr); end
      checks++; if (busy !== 1'b0)     begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
   endtask

   task automatic test_write_burst();
      logic [7:0] bytes [4];
      logic ack;
      int base;
      bytes[0] = 8'h92;  bytes[1] = 8'h03;  bytes[2] = 8'hAA;  bytes[3] = 8'hBB;
      base = wr_cnt;
      i2c_start();
      for (int i = 0; i < 4; i++) begin
         write_byte(bytes[i], -1, ack);
         checks++; if (ack !== 1'b0) begin errors++; $display("FAIL wr_ack byte%0d got %b want 0", i, ack); end
      end
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL wr_busy_mid got %b want 1", busy); end
      i2c_stop();
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL wr_busy_stop got %b want 0", busy); end
      checks++; if (wr_cnt - base !== 2) begin errors++; $display("FAIL wr_count got %0d want 2", wr_cnt - base); end
      checks++; if (wr_a_log[base] !== 4'd3 || wr_d_log[base] !== 8'hAA)
         begin errors++; $display("FAIL wr_first got (%0d,%0h) want (3,aa)", wr_a_log[base], wr_d_log[base]); end
      checks++; if (wr_a_log[base+1] !== 4'd4 || wr_d_log[base+1] !== 8'hBB)
         begin errors++; $display("FAIL wr_second got (%0d,%0h) want (4,bb)", wr_a_log[base+1], wr_d_log[base+1]); end
   endtask

   task automatic test_read_rstart();
      logic ack;
      logic [7:0] d0, d1;
      int base;
      base = rd_cnt;
      i2c_start();
      write_byte(8'h92, -1, ack);
      write_byte(8'h05, -1, ack);
      checks++; if (ack !== 1'b0) begin errors++; $display("FAIL rd_ptr_ack got %b want 0", ack); end
      i2c_start();
      write_byte(8'h93, -1, ack);
      checks++; if (ack !== 1'b0) begin errors++; $display("FAIL rd_addr_ack got %b want 0", ack); end
      read_byte(1'b0, d0);
      read_byte(1'b1, d1);
      checks++; if (d0 !== 8'h5A) begin errors++; $display("FAIL rd_byte0 got %0h want 5a", d0); end
      checks++; if (d1 !== 8'hC3) begin errors++; $display("FAIL rd_byte1 got %0h want c3", d1); end
      checks++; if (sda_oe !== 1'b0) begin errors++; $display("FAIL rd_release_after_nack got %b want 0", sda_oe); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rd_busy_after_nack got %b want 0", busy); end
      i2c_stop();
      checks++; if (rd_cnt - base !== 2) begin errors++; $display("FAIL rd_req_count got %0d want 2", rd_cnt - base); end
      checks++; if (rd_a_log[base] !== 4'd5 || rd_a_log[base+1] !== 4'd6)
         begin errors++; $display("FAIL rd_req_addrs got %0d,%0d want 5,6", rd_a_log[base], rd_a_log[base+1]); end
   endtask

   task automatic test_other_addr();
      logic ack;
      int wbase, obase;
      wbase = wr_cnt;  obase = oe_cycles;
      i2c_start();
      write_byte(8'h90, -1, ack);
      checks++; if (ack !== 1'b1) begin errors++; $display("FAIL other_ack got %b want 1", ack); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL other_busy got %b want 0", busy); end
      write_byte(8'h12, -1, ack);
      write_byte(8'h34, -1, ack);
      i2c_stop();
      checks++; if (oe_cycles - obase !== 0) begin errors++; $display("FAIL other_sda_oe got %0d cycles want 0", oe_cycles - obase); end
      checks++; if (wr_cnt - wbase !== 0) begin errors++; $display("FAIL other_writes got %0d want 0", wr_cnt - wbase); end
   endtask

   task automatic test_bad_ptr();
      logic ack;
      logic [7:0] d;
      int wbase, rbase;
      wbase = wr_cnt;  rbase = rd_cnt;
      i2c_start();
      write_byte(8'h92, -1, ack);
      write_byte(8'h10, -1, ack);
      checks++; if (ack !== 1'b1) begin errors++; $display("FAIL badptr_nack got %b want 1", ack); end
      write_byte(8'h77, -1, ack);
      i2c_stop();
      checks++; if (wr_cnt - wbase !== 0) begin errors++; $display("FAIL badptr_writes got %0d want 0", wr_cnt - wbase); end
      i2c_start();
      write_byte(8'h93, -1, ack);
      read_byte(1'b1, d);
      i2c_stop();
      checks++; if (d !== 8'hC3) begin errors++; $display("FAIL badptr_read got %0h want c3", d); end
      checks++; if (rd_a_log[rbase] !== 4'd6) begin errors++; $display("FAIL badptr_rd_addr got %0d want 6", rd_a_log[rbase]); end
   endtask

   task automatic test_wrap_glitch();
      logic ack;
      int base;
      base = wr_cnt;
      i2c_start();
      write_byte(8'h92, -1, ack);
      write_byte(8'h0F, -1, ack);
      write_byte(8'h11, 3, ack);
      write_byte(8'h22, -1, ack);
      write_byte(8'h33, 0, ack);
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL wrap_busy got %b want 1", busy); end
      i2c_stop();
      checks++; if (wr_cnt - base !== 3) begin errors++; $display("FAIL wrap_count got %0d want 3", wr_cnt - base); end
      checks++; if (wr_a_log[base] !== 4'd15 || wr_d_log[base] !== 8'h11)
         begin errors++; $display("FAIL wrap_w0 got (%0d,%0h) want (15,11)", wr_a_log[base], wr_d_log[base]); end
      checks++; if (wr_a_log[base+1] !== 4'd0 || wr_d_log[base+1] !== 8'h22)
         begin errors++; $display("FAIL wrap_w1 got (%0d,%0h) want (0,22)", wr_a_log[base+1], wr_d_log[base+1]); end
      checks++; if (wr_a_log[base+2] !== 4'd1 || wr_d_log[base+2] !== 8'h33)
         begin errors++; $display("FAIL wrap_w2 got (%0d,%0h) want (1,33)", wr_a_log[base+2], wr_d_log[base+2]); end
   endtask

   task automatic test_reset_mid_read();
      logic ack;
      logic [7:0] d;
      int rbase, wbase;
      i2c_start();
      write_byte(8'h93, -1, ack);
      read_bits(4, d);
      checks++; if (sda_oe !== 1'b1) begin errors++; $display("FAIL midread_driving got %b want 1", sda_oe); end
      reset = 1'b1;
      wait_clk(1);
      checks++; if (sda_oe !== 1'b0) begin errors++; $display("FAIL midread_release got %b want 0", sda_oe); end
      checks++; if (busy !== 1'b0 || rd_req !== 1'b0 || wr_valid !== 1'b0)
         begin errors++; $display("FAIL midread_ctrl got busy=%b rd_req=%b wr_valid=%b want 0", busy, rd_req, wr_valid); end
      checks++; if (rd_addr !== 4'd0 || wr_addr !== 4'd0 || wr_data !== 8'd0)
         begin errors++; $display("FAIL midread_regs got rd_addr=%0d wr_addr=%0d wr_data=%0h want 0", rd_addr, wr_addr, wr_data); end
      scl_m = 1'b1;  sda_m = 1'b1;
      wait_clk(3);
      reset = 1'b0;
      wait_clk(20);
      rbase = rd_cnt;
      i2c_start();
      write_byte(8'h93, -1, ack);
      read_byte(1'b1, d);
      i2c_stop();
      checks++; if (d !== 8'hA5) begin errors++; $display("FAIL postreset_read got %0h want a5", d); end
      checks++; if (rd_a_log[rbase] !== 4'd0) begin errors++; $display("FAIL postreset_ptr got %0d want 0", rd_a_log[rbase]); end
      wbase = wr_cnt;
      i2c_start();
      write_byte(8'h92, -1, ack);
      write_byte(8'h07, -1, ack);
      write_byte(8'h5E, -1, ack);
      checks++; if (ack !== 1'b0) begin errors++; $display("FAIL postreset_ack got %b want 0", ack); end
      i2c_stop();
      checks++; if (wr_cnt - wbase !== 1 || wr_a_log[wbase] !== 4'd7 || wr_d_log[wbase] !== 8'h5E)
         begin errors++; $display("FAIL postreset_write got n=%0d (%0d,%0h) want n=1 (7,5e)", wr_cnt - wbase, wr_a_log[wbase], wr_d_log[wbase]); end
   endtask

   task automatic test_strobes();
      checks++; if (overlap !== 0) begin errors++; $display("FAIL strobe_overlap got %0d want 0", overlap); end
      checks++; if (long_pulse !== 0) begin errors++; $display("FAIL strobe_length got %0d want 0", long_pulse); end
   endtask

   initial begin
      for (int i = 0; i < 16; i++) regs[i] = 8'hFF;
      regs[0] = 8'hA5;
      regs[2] = 8'h00;
      regs[5] = 8'h5A;
      regs[6] = 8'hC3;
      test_reset();
      test_write_burst();
      test_read_rstart();
      test_other_addr();
      test_bad_ptr();
      test_wrap_glitch();
      test_reset_mid_read();
      test_strobes();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
